// File: rtl/tank_cycle_controller.sv
// Fill/hold/drain tank sequencer with a 2-digit BCD countdown per phase.
// Asynchronous inputs are double-flopped; outputs are registered and change only on clk.
module tank_cycle_controller #(
  parameter int TICK_DIV   = 50000000,
  parameter int CNT_W      = 26,
  parameter int FILL_TIME  = 30,
  parameter int HOLD_TIME  = 15,
  parameter int DRAIN_TIME = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       level_full,
  input  logic       level_empty,
  output logic [1:0] state,
  output logic [3:0] Ds,
  output logic [3:0] Us,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_HOLD  = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  localparam logic [3:0]       FILL_D    = 4'(FILL_TIME / 10);
  localparam logic [3:0]       FILL_U    = 4'(FILL_TIME % 10);
  localparam logic [3:0]       HOLD_D    = 4'(HOLD_TIME / 10);
  localparam logic [3:0]       HOLD_U    = 4'(HOLD_TIME % 10);
  localparam logic [3:0]       DRAIN_D   = 4'(DRAIN_TIME / 10);
  localparam logic [3:0]       DRAIN_U   = 4'(DRAIN_TIME % 10);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic r_start_s1, r_start_s2, r_start_s3;
  logic r_stop_s1, r_stop_s2;
  logic r_full_s1, r_full_s2;
  logic r_empty_s1, r_empty_s2;

  state_t           r_state, w_state_next;
  logic [3:0]       r_ds, w_ds_next;
  logic [3:0]       r_us, w_us_next;
  logic             r_done, w_done_next;
  logic [CNT_W-1:0] r_presc, w_presc_next;

  logic       w_start_evt;
  logic       w_tick;
  logic       w_expire;
  logic [3:0] w_dec_ds;
  logic [3:0] w_dec_us;

  // The whole start chain resets high so a start held through reset release
  // looks like an already-seen level rather than a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s1 <= 1'b1;
      r_start_s2 <= 1'b1;
      r_start_s3 <= 1'b1;
      r_stop_s1  <= 1'b0;
      r_stop_s2  <= 1'b0;
      r_full_s1  <= 1'b0;
      r_full_s2  <= 1'b0;
      r_empty_s1 <= 1'b0;
      r_empty_s2 <= 1'b0;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_s3 <= r_start_s2;
      r_stop_s1  <= stop;
      r_stop_s2  <= r_stop_s1;
      r_full_s1  <= level_full;
      r_full_s2  <= r_full_s1;
      r_empty_s1 <= level_empty;
      r_empty_s2 <= r_empty_s1;
    end
  end

  assign w_start_evt = r_start_s2 & ~r_start_s3;
  assign w_tick      = (r_state != S_IDLE) && (r_presc == TICK_LAST);
  assign w_expire    = w_tick && (r_ds == 4'd0) && (r_us == 4'd1);
  assign w_dec_us    = (r_us != 4'd0) ? r_us - 4'd1 : 4'd9;
  assign w_dec_ds    = (r_us != 4'd0) ? r_ds : r_ds - 4'd1;

  always_comb begin
    w_state_next = r_state;
    w_ds_next    = r_ds;
    w_us_next    = r_us;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_evt) begin
          w_state_next = S_FILL;
          w_ds_next    = FILL_D;
          w_us_next    = FILL_U;
        end
      end
      S_FILL: begin
        if (r_stop_s2) begin
          w_state_next = S_DRAIN;
          w_ds_next    = DRAIN_D;
          w_us_next    = DRAIN_U;
        end else if (r_full_s2 || w_expire) begin
          w_state_next = S_HOLD;
          w_ds_next    = HOLD_D;
          w_us_next    = HOLD_U;
        end else if (w_tick) begin
          w_ds_next    = w_dec_ds;
          w_us_next    = w_dec_us;
        end
      end
      S_HOLD: begin
        if (r_stop_s2 || w_expire) begin
          w_state_next = S_DRAIN;
          w_ds_next    = DRAIN_D;
          w_us_next    = DRAIN_U;
        end else if (w_tick) begin
          w_ds_next    = w_dec_ds;
          w_us_next    = w_dec_us;
        end
      end
      S_DRAIN: begin
        // stop is deliberately not looked at: a drain always runs to completion.
        if (r_empty_s2 || w_expire) begin
          w_state_next = S_IDLE;
          w_ds_next    = 4'd0;
          w_us_next    = 4'd0;
          w_done_next  = 1'b1;
        end else if (w_tick) begin
          w_ds_next    = w_dec_ds;
          w_us_next    = w_dec_us;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ds_next    = 4'd0;
        w_us_next    = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_presc_next = r_presc + CNT_W'(1);
    if ((w_state_next != r_state) || (r_state == S_IDLE) || w_tick) begin
      w_presc_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ds    <= 4'd0;
      r_us    <= 4'd0;
      r_done  <= 1'b0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_next;
      r_ds    <= w_ds_next;
      r_us    <= w_us_next;
      r_done  <= w_done_next;
      r_presc <= w_presc_next;
    end
  end

  assign state = r_state;
  assign Ds    = r_ds;
  assign Us    = r_us;
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;

endmodule
